// File: rtl/ahb_decoder_mux.sv
// AHB-Lite address decoder and slave response multiplexer with a built-in
// default (ERROR) slave, per-transfer timeout watchdog and first-error log.
module ahb_decoder_mux #(
  parameter int NSLAVES = 8,
  parameter int PA_BITS = 34,
  parameter int DW      = 64,
  parameter logic [NSLAVES-1:0][PA_BITS-1:0] BASES  = '0,
  parameter logic [NSLAVES-1:0][PA_BITS-1:0] RANGES = '0,
  parameter int TIMEOUT = 256
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic [PA_BITS-1:0]    HADDR,
  input  logic [1:0]            HTRANS,
  output logic [NSLAVES-1:0]    HSELS,
  input  logic [NSLAVES-1:0]    HREADYOUTS,
  input  logic [NSLAVES-1:0]    HRESPS,
  input  logic [NSLAVES*DW-1:0] HRDATAS,
  output logic [DW-1:0]         HRDATA,
  output logic                  HREADY,
  output logic                  HRESP,
  input  logic                  ErrClear,
  output logic                  ErrValid,
  output logic                  ErrCause,
  output logic [PA_BITS-1:0]    ErrAddr
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] C_TLAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
  localparam logic [CW-1:0] C_CSAT  = '1;

  localparam logic [1:0] S_NORMAL = 2'd0;
  localparam logic [1:0] S_ERR1   = 2'd1;
  localparam logic [1:0] S_ERR2   = 2'd2;

  logic [1:0]         r_state;
  logic [NSLAVES-1:0] r_sel;
  logic [PA_BITS-1:0] r_dpAddr;
  logic [CW-1:0]      r_cnt;
  logic               r_errValid;
  logic               r_errCause;
  logic [PA_BITS-1:0] r_errAddr;

  logic [NSLAVES-1:0] w_hsels;
  logic               w_miss;
  logic [DW-1:0]      w_slvData;
  logic               w_slvReady;
  logic               w_slvResp;
  logic               w_decErr;
  logic               w_timeout;
  logic [1:0]         w_stateNext;
  logic               w_errEnter;

  // Descending scan so the lowest matching index is the last one written.
  always_comb begin
    w_hsels = '0;
    for (int i = NSLAVES - 1; i >= 0; i--) begin
      if ((HADDR & ~RANGES[i]) == BASES[i]) begin
        w_hsels    = '0;
        w_hsels[i] = 1'b1;
      end
    end
  end

  assign HSELS  = w_hsels;
  assign w_miss = ~|w_hsels;

  always_comb begin
    w_slvData  = '0;
    w_slvReady = 1'b1;
    w_slvResp  = 1'b0;
    for (int i = 0; i < NSLAVES; i++) begin
      if (r_sel[i]) begin
        w_slvData  = HRDATAS[i*DW +: DW];
        w_slvReady = HREADYOUTS[i];
        w_slvResp  = HRESPS[i];
      end
    end
  end

  always_comb begin
    HRDATA = '0;
    HREADY = 1'b1;
    HRESP  = 1'b0;
    case (r_state)
      S_ERR1: begin
        HREADY = 1'b0;
        HRESP  = 1'b1;
      end
      S_ERR2: begin
        HREADY = 1'b1;
        HRESP  = 1'b1;
      end
      default: begin
        HRDATA = w_slvData;
        HREADY = w_slvReady;
        HRESP  = w_slvResp;
      end
    endcase
  end

  // A decode error enters ERR1 on the edge that opens its data phase, so the
  // first data cycle already shows the ERROR wait state.
  assign w_decErr  = HREADY & w_miss & HTRANS[1];
  assign w_timeout = (TIMEOUT != 0) && (r_state == S_NORMAL) && (|r_sel) &&
                     (r_cnt == C_TLAST) && !w_slvReady;

  always_comb begin
    w_stateNext = S_NORMAL;
    case (r_state)
      S_NORMAL: w_stateNext = (w_decErr || w_timeout) ? S_ERR1 : S_NORMAL;
      S_ERR1:   w_stateNext = S_ERR2;
      S_ERR2:   w_stateNext = w_decErr ? S_ERR1 : S_NORMAL;
      default:  w_stateNext = S_NORMAL;
    endcase
  end

  assign w_errEnter = (w_stateNext == S_ERR1) && (r_state != S_ERR1);

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      r_state    <= S_NORMAL;
      r_sel      <= '0;
      r_dpAddr   <= '0;
      r_cnt      <= '0;
      r_errValid <= 1'b0;
      r_errCause <= 1'b0;
      r_errAddr  <= '0;
    end else begin
      r_state <= w_stateNext;
      if (HREADY) begin
        r_sel    <= w_hsels;
        r_dpAddr <= HADDR;
      end
      if (HREADY || w_errEnter)
        r_cnt <= '0;
      else if ((r_state == S_NORMAL) && (|r_sel) && (r_cnt != C_CSAT))
        r_cnt <= r_cnt + 1'b1;
      // A new error logged together with ErrClear takes precedence.
      if (w_errEnter && (!r_errValid || ErrClear)) begin
        r_errValid <= 1'b1;
        r_errCause <= w_timeout;
        r_errAddr  <= w_timeout ? r_dpAddr : HADDR;
      end else if (ErrClear) begin
        r_errValid <= 1'b0;
        r_errCause <= 1'b0;
        r_errAddr  <= '0;
      end
    end
  end

  assign ErrValid = r_errValid;
  assign ErrCause = r_errCause;
  assign ErrAddr  = r_errAddr;

endmodule

// File: tb/tb_ahb_decoder_mux.sv
// Directed bench for ahb_decoder_mux: one 4-region instance with an 8-cycle
// watchdog, one with overlapping regions and the watchdog disabled.
module tb_ahb_decoder_mux;

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] BUSY   = 2'b01;
  localparam logic [1:0] NONSEQ = 2'b10;
  localparam logic [31:0] PARK_A = 32'h0000_8000;
  localparam logic [31:0] PARK_B = 32'h0009_0000;

  localparam logic [3:0][31:0] A_BASES  = {32'h3000, 32'h2000, 32'h1000, 32'h0000};
  localparam logic [3:0][31:0] A_RANGES = {32'hFFF, 32'hFFF, 32'hFFF, 32'hFFF};
  localparam logic [3:0][31:0] B_BASES  = {32'h30000, 32'h1000, 32'h20000, 32'h0};
  localparam logic [3:0][31:0] B_RANGES = {32'hFFF, 32'hFF, 32'hFFF, 32'hFFFF};

  logic        HCLK = 1'b0;
  logic        HRESETn;

  logic [31:0]  aAddr, aRdata, aErrAddr;
  logic [1:0]   aTrans;
  logic [3:0]   aSels, aReadyOuts, aResps;
  logic [127:0] aRdatas;
  logic         aReady, aResp, aClr, aErrValid, aErrCause;

  logic [31:0]  bAddr, bRdata, bErrAddr;
  logic [1:0]   bTrans;
  logic [3:0]   bSels, bReadyOuts, bResps;
  logic [127:0] bRdatas;
  logic         bReady, bResp, bClr, bErrValid, bErrCause;

  int testsRun    = 0;
  int testsFailed = 0;

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  trans;
    logic [3:0]  selA;
    logic [3:0]  selB;
  } decVec_t;

  decVec_t vecs[12];

  ahb_decoder_mux #(
    .NSLAVES(4), .PA_BITS(32), .DW(32),
    .BASES(A_BASES), .RANGES(A_RANGES), .TIMEOUT(8)
  ) dutA (
    .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(aAddr), .HTRANS(aTrans),
    .HSELS(aSels), .HREADYOUTS(aReadyOuts), .HRESPS(aResps), .HRDATAS(aRdatas),
    .HRDATA(aRdata), .HREADY(aReady), .HRESP(aResp), .ErrClear(aClr),
    .ErrValid(aErrValid), .ErrCause(aErrCause), .ErrAddr(aErrAddr)
  );

  ahb_decoder_mux #(
    .NSLAVES(4), .PA_BITS(32), .DW(32),
    .BASES(B_BASES), .RANGES(B_RANGES), .TIMEOUT(0)
  ) dutB (
    .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(bAddr), .HTRANS(bTrans),
    .HSELS(bSels), .HREADYOUTS(bReadyOuts), .HRESPS(bResps), .HRDATAS(bRdatas),
    .HRDATA(bRdata), .HREADY(bReady), .HRESP(bResp), .ErrClear(bClr),
    .ErrValid(bErrValid), .ErrCause(bErrCause), .ErrAddr(bErrAddr)
  );

  always #5 HCLK = ~HCLK;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic applyStimulus(input logic [31:0] addr, input logic [1:0] trans);
    aAddr  = addr;
    aTrans = trans;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic restoreSlaves();
    for (int i = 0; i < 4; i++) begin
      aRdatas[i*32 +: 32] = 32'hA0A0_0000 + i;
      bRdatas[i*32 +: 32] = 32'hB0B0_0000 + i;
    end
    aReadyOuts = 4'hF;
    bReadyOuts = 4'hF;
  endtask

  initial begin
    int sawErr;

    vecs[0]  = '{32'h0000_1010, IDLE, 4'b0010, 4'b0001};
    vecs[1]  = '{32'h0000_1004, BUSY, 4'b0010, 4'b0001};
    vecs[2]  = '{32'h0000_0000, IDLE, 4'b0001, 4'b0001};
    vecs[3]  = '{32'h0000_0FFF, BUSY, 4'b0001, 4'b0001};
    vecs[4]  = '{32'h0000_2ABC, IDLE, 4'b0100, 4'b0001};
    vecs[5]  = '{32'h0000_3FFF, BUSY, 4'b1000, 4'b0001};
    vecs[6]  = '{32'h0000_4000, IDLE, 4'b0000, 4'b0001};
    vecs[7]  = '{32'h0000_9000, BUSY, 4'b0000, 4'b0001};
    vecs[8]  = '{32'h0002_0010, IDLE, 4'b0000, 4'b0010};
    vecs[9]  = '{32'h0003_0FFF, BUSY, 4'b0000, 4'b1000};
    vecs[10] = '{32'h0001_1004, IDLE, 4'b0000, 4'b0000};
    vecs[11] = '{32'h8000_1000, BUSY, 4'b0000, 4'b0000};

    HRESETn = 1'b0;
    aAddr = PARK_A; aTrans = IDLE; aResps = '0; aClr = 1'b0;
    bAddr = PARK_B; bTrans = IDLE; bResps = '0; bClr = 1'b0;
    restoreSlaves();

    repeat (3) @(posedge HCLK);
    #1;
    checkOutput("reset HREADY A", 64'(aReady), 64'd1);
    checkOutput("reset HRESP A", 64'(aResp), 64'd0);
    checkOutput("reset HRDATA A", 64'(aRdata), 64'd0);
    checkOutput("reset ErrValid A", 64'(aErrValid), 64'd0);
    checkOutput("reset ErrAddr A", 64'(aErrAddr), 64'd0);
    checkOutput("reset HREADY B", 64'(bReady), 64'd1);
    HRESETn = 1'b1;

    // Decode table, including overlap priority on dutB; no errors may log.
    for (int v = 0; v < 12; v++) begin
      tick();
      bAddr  = vecs[v].addr;
      bTrans = vecs[v].trans;
      applyStimulus(vecs[v].addr, vecs[v].trans);
      checkOutput($sformatf("decode A vec%0d", v), 64'(aSels), 64'(vecs[v].selA));
      checkOutput($sformatf("decode B vec%0d", v), 64'(bSels), 64'(vecs[v].selB));
    end
    tick();
    bAddr = PARK_B; bTrans = IDLE;
    applyStimulus(PARK_A, IDLE);
    checkOutput("unmapped idle no log A", 64'(aErrValid), 64'd0);
    checkOutput("unmapped idle no log B", 64'(bErrValid), 64'd0);

    // Mapped read with two wait states.
    tick();
    applyStimulus(32'h1010, NONSEQ);
    checkOutput("read HSELS", 64'(aSels), 64'b0010);
    checkOutput("read addr HREADY", 64'(aReady), 64'd1);
    tick();
    aReadyOuts[1] = 1'b0;
    applyStimulus(PARK_A, IDLE);
    checkOutput("read wait1 HREADY", 64'(aReady), 64'd0);
    tick();
    #1;
    checkOutput("read wait2 HREADY", 64'(aReady), 64'd0);
    tick();
    aReadyOuts[1] = 1'b1;
    aRdatas[32 +: 32] = 32'hDEAD_BEEF;
    #1;
    checkOutput("read done HREADY", 64'(aReady), 64'd1);
    checkOutput("read done HRDATA", 64'(aRdata), 64'hDEAD_BEEF);
    checkOutput("read done HRESP", 64'(aResp), 64'd0);
    tick();
    restoreSlaves();
    #1;

    // Decode error: one ERROR wait state, then ERROR completion.
    tick();
    applyStimulus(32'h9000, NONSEQ);
    checkOutput("decerr HSELS", 64'(aSels), 64'd0);
    tick();
    applyStimulus(PARK_A, IDLE);
    checkOutput("decerr c1 HREADY/HRESP", 64'({aReady, aResp}), 64'b01);
    checkOutput("decerr c1 HRDATA", 64'(aRdata), 64'd0);
    checkOutput("decerr log", 64'({aErrValid, aErrCause}), 64'b10);
    checkOutput("decerr ErrAddr", 64'(aErrAddr), 64'h9000);
    tick();
    #1;
    checkOutput("decerr c2 HREADY/HRESP", 64'({aReady, aResp}), 64'b11);
    tick();
    #1;
    checkOutput("decerr after HREADY/HRESP", 64'({aReady, aResp}), 64'b10);

    // A second error must not overwrite the log.
    tick();
    applyStimulus(32'hB000, NONSEQ);
    tick();
    applyStimulus(PARK_A, IDLE);
    checkOutput("2nd err c1 HREADY/HRESP", 64'({aReady, aResp}), 64'b01);
    tick();
    #1;
    checkOutput("2nd err c2 HREADY/HRESP", 64'({aReady, aResp}), 64'b11);
    checkOutput("2nd err ErrAddr kept", 64'(aErrAddr), 64'h9000);

    // ErrClear coincident with a new error: the new error is logged.
    tick();
    aClr = 1'b1;
    applyStimulus(32'hA000, NONSEQ);
    tick();
    aClr = 1'b0;
    applyStimulus(PARK_A, IDLE);
    checkOutput("clr+err ErrValid", 64'(aErrValid), 64'd1);
    checkOutput("clr+err ErrAddr", 64'(aErrAddr), 64'hA000);
    tick();
    tick();

    tick();
    aClr = 1'b1;
    #1;
    tick();
    aClr = 1'b0;
    #1;
    checkOutput("clear ErrValid", 64'(aErrValid), 64'd0);
    checkOutput("clear ErrAddr", 64'(aErrAddr), 64'd0);

    // IDLE to an unmapped address: zero-wait OKAY, no log.
    tick();
    applyStimulus(32'h9000, IDLE);
    tick();
    applyStimulus(PARK_A, IDLE);
    checkOutput("idle unmapped HREADY/HRESP", 64'({aReady, aResp}), 64'b10);
    checkOutput("idle unmapped no log", 64'(aErrValid), 64'd0);

    // Timeout on hung slave3, then back-to-back NONSEQ issued in ERR2.
    tick();
    aReadyOuts[3] = 1'b0;
    applyStimulus(32'h3000, NONSEQ);
    checkOutput("timeout HSELS", 64'(aSels), 64'b1000);
    for (int k = 1; k <= 8; k++) begin
      tick();
      applyStimulus(PARK_A, IDLE);
      checkOutput($sformatf("timeout wait%0d", k), 64'({aReady, aResp}), 64'b00);
    end
    tick();
    #1;
    checkOutput("timeout ERR1 HREADY/HRESP", 64'({aReady, aResp}), 64'b01);
    checkOutput("timeout log", 64'({aErrValid, aErrCause}), 64'b11);
    checkOutput("timeout ErrAddr", 64'(aErrAddr), 64'h3000);
    tick();
    applyStimulus(32'h1020, NONSEQ);
    checkOutput("timeout ERR2 HREADY/HRESP", 64'({aReady, aResp}), 64'b11);
    checkOutput("b2b HSELS", 64'(aSels), 64'b0010);
    tick();
    aRdatas[32 +: 32] = 32'h1234_5678;
    applyStimulus(PARK_A, IDLE);
    checkOutput("b2b HREADY/HRESP", 64'({aReady, aResp}), 64'b10);
    checkOutput("b2b HRDATA", 64'(aRdata), 64'h1234_5678);
    tick();
    restoreSlaves();
    #1;

    // Reset for one edge while in ERR1.
    tick();
    applyStimulus(32'h9000, NONSEQ);
    tick();
    applyStimulus(PARK_A, IDLE);
    checkOutput("pre-reset ERR1", 64'({aReady, aResp}), 64'b01);
    HRESETn = 1'b0;
    tick();
    HRESETn = 1'b1;
    #1;
    checkOutput("post-reset HREADY/HRESP", 64'({aReady, aResp}), 64'b10);
    checkOutput("post-reset log", 64'({aErrValid, aErrCause}), 64'b00);
    checkOutput("post-reset ErrAddr", 64'(aErrAddr), 64'd0);
    tick();
    #1;
    checkOutput("post-reset NORMAL", 64'({aReady, aResp}), 64'b10);

    // Watchdog disabled: a hung slave stalls forever without error.
    tick();
    bAddr = 32'h0000_0100; bTrans = NONSEQ;
    bReadyOuts[0] = 1'b0;
    #1;
    checkOutput("hang HSELS B", 64'(bSels), 64'b0001);
    tick();
    bAddr = PARK_B; bTrans = IDLE;
    #1;
    sawErr = 0;
    for (int k = 0; k < 1000; k++) begin
      if (bReady !== 1'b0 || bResp !== 1'b0 || bErrValid !== 1'b0) sawErr++;
      tick();
    end
    checkOutput("no-timeout hang cycles", 64'(sawErr), 64'd0);
    bReadyOuts[0] = 1'b1;
    bRdatas[0 +: 32] = 32'hCAFE_F00D;
    #1;
    checkOutput("hang release HREADY/HRESP", 64'({bReady, bResp}), 64'b10);
    checkOutput("hang release HRDATA", 64'(bRdata), 64'hCAFE_F00D);
    tick();
    #1;
    checkOutput("hang no log B", 64'(bErrValid), 64'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
